prog_delay_line: RTL and testbench
==================================

Name: prog_delay_line

Overview:
- Clocked, runtime-programmable delay line for a SIZE-bit bus, with a valid qualifier.
- Successor to the fixed, per-bit delay element used in the async library: the delay is a number of enabled clock cycles, selectable from 0 to MAX_DELAY at run time.
- Supports stall (en), flush on reprogramming, and a busy flag while the line refills.
- Used wherever a bundled-data path needs a matched, tunable latency inside the synchronous domain.

Parameters:
- SIZE, 8: data width in bits.
- MAX_DELAY, 16: maximum delay in cycles and buffer depth; must be >= 1.
- DEFAULT_DELAY, 1: delay value loaded at reset; must be <= MAX_DELAY.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: advance enable; when 0, all state holds.
- delay_load, input, 1: load delay_sel as the new delay.
- delay_sel, input, $clog2(MAX_DELAY+1): requested delay in cycles.
- valid_in, input, 1: data_in qualifier.
- data_in, input, SIZE: data sample.
- valid_out, output, 1: delayed valid_in.
- data_out, output, SIZE: delayed data; forced to 0 when valid_out=0.
- busy, output, 1: high while the line holds fewer than cur_delay samples since the last reset or load.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high. Ports are named clk and rst.
  - Reset clears wr_ptr, all stored valid bits and fill to 0, and sets cur_delay to DEFAULT_DELAY.
  - After reset: valid_out=0, data_out=0, busy=(DEFAULT_DELAY!=0).
  - Stored data bits are not reset.
  - rst overrides en and delay_load in the same cycle.
- Storage:
  - Circular buffer mem[0..MAX_DELAY-1] of {valid, data}.
  - When en=1: mem[wr_ptr] <= {valid_in, data_in} and wr_ptr advances. It wraps from MAX_DELAY-1 to 0.
- Read path, cur_delay = d >= 1:
  - Combinational read of mem[(wr_ptr - d) mod MAX_DELAY].
  - A sample written at enabled edge k appears at the output after the d-th enabled edge counted from k (inclusive). With en held at 1, latency is exactly d cycles.
  - The modular subtraction must be correct for non-power-of-2 MAX_DELAY.
- Bypass, d = 0: data_out and valid_out follow data_in and valid_in combinationally (with the zero-gating of data_out); busy=0.
- Stall (en=0): wr_ptr, mem and fill hold, so the outputs hold as well. delay_load is still honoured during a stall.
- Delay load, delay_load=1 at an edge:
  - cur_delay <= min(delay_sel, MAX_DELAY); out-of-range values are clamped, not rejected.
  - All stored valid bits are cleared (flush), so no sample is duplicated or skipped across the change.
  - fill <= 0.
  - If en=1 in the same cycle, the write of {valid_in, data_in} still occurs and is kept, and it counts as fill=1.
- Fill counter: increments on each enabled edge, saturating at cur_delay; busy = (fill < cur_delay).
- Output gating: data_out = valid_out ? stored data : 0.
- Wrap: pointer wrap must be seamless. d = MAX_DELAY reads the slot about to be overwritten; the old value is output until the edge.

Test Plan:
- Reset then steady stream: DEFAULT_DELAY=1, SIZE=8, MAX_DELAY=16, en=1, feed valid data 0x01,0x02,… each cycle. Required: valid_out=0 and data_out=0 in cycle 0; data_out=0x01 one cycle after its input, then one value per cycle; busy drops after 1 edge.
- Maximum delay with wrap: load 16, stream 40 incrementing values. Required: valid_out low for 16 cycles after the load; then data_out(t) = data_in(t-16) for all t across two pointer wraps.
- Stall: delay 4, stream values, drop en for 3 cycles mid-stream. Required: outputs frozen for those 3 cycles; sequence resumes with no gap or duplicate; effective latency is 4 enabled edges.
- Reprogram and clamp: while streaming at delay 3, assert delay_load with delay_sel=20. Required: cur_delay=16; valid_out=0 and busy=1 for 16 enabled cycles; the first output is the sample written in the load cycle.
- Bypass: load 0, drive valid_in=1, data_in=0xA5. Required: same-cycle valid_out=1, data_out=0xA5, busy=0. With valid_in=0: data_out=0x00.
- Reset mid-operation: at delay 5 with the line full, assert rst for one cycle alongside delay_load=1. Required: cur_delay=DEFAULT_DELAY (load ignored); valid_out=0 next cycle; no pre-reset samples ever reappear.

Source files
------------

// File: rtl/prog_delay_line_if.sv
// prog_delay_line_if: delay-line bus (en, delay_load/delay_sel, valid_in/data_in in; valid_out/data_out/busy out)
interface prog_delay_line_if #(
  parameter int SIZE = 8,
  parameter int MAX_DELAY = 16
);
  localparam int DW = $clog2(MAX_DELAY + 1);
  logic en;
  logic delay_load;
  logic [DW-1:0] delay_sel;
  logic valid_in;
  logic [SIZE-1:0] data_in;
  logic valid_out;
  logic [SIZE-1:0] data_out;
  logic busy;
  modport master (
    output en, delay_load, delay_sel, valid_in, data_in,
    input valid_out, data_out, busy
  );
  modport slave (
    input en, delay_load, delay_sel, valid_in, data_in,
    output valid_out, data_out, busy
  );
endinterface

// File: rtl/prog_delay_line.sv
// prog_delay_line: runtime-programmable 0..MAX_DELAY cycle delay line (clk, rst, bus: en/delay_load/delay_sel/valid_in/data_in -> valid_out/data_out/busy)
module prog_delay_line #(
  parameter int SIZE = 8,
  parameter int MAX_DELAY = 16,
  parameter int DEFAULT_DELAY = 1
) (
  input logic clk,
  input logic rst,
  prog_delay_line_if.slave bus
);
  localparam int DW = $clog2(MAX_DELAY + 1);
  localparam int PW = MAX_DELAY > 1 ? $clog2(MAX_DELAY) : 1;
  localparam int AW = DW + 1;
  logic [SIZE-1:0] mem_d [MAX_DELAY];
  logic [MAX_DELAY-1:0] mem_v;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd;
  logic [DW-1:0] cur_delay;
  logic [DW-1:0] fill;
  logic [DW-1:0] new_delay;
  logic [AW-1:0] sum;
  // wr_ptr + MAX_DELAY - d never underflows and is < 2*MAX_DELAY, so one conditional subtract gives the modulo
  always_comb begin
    sum = AW'(wr_ptr) + AW'(MAX_DELAY) - AW'(cur_delay);
    rd = PW'(sum >= AW'(MAX_DELAY) ? sum - AW'(MAX_DELAY) : sum);
    new_delay = bus.delay_sel > DW'(MAX_DELAY) ? DW'(MAX_DELAY) : bus.delay_sel;
    bus.valid_out = cur_delay == '0 ? bus.valid_in : mem_v[rd];
    bus.data_out = !bus.valid_out ? '0 : cur_delay == '0 ? bus.data_in : mem_d[rd];
    bus.busy = fill < cur_delay;
  end
  always_ff @(posedge clk)
    if (bus.en && !rst) mem_d[wr_ptr] <= bus.data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      mem_v <= '0;
      fill <= '0;
      cur_delay <= DW'(DEFAULT_DELAY);
    end else begin
      if (bus.delay_load) begin
        cur_delay <= new_delay;
        fill <= (bus.en && new_delay != '0) ? DW'(1) : '0;
        mem_v <= '0;
        if (bus.en) mem_v[wr_ptr] <= bus.valid_in;
      end else if (bus.en) begin
        fill <= fill < cur_delay ? fill + DW'(1) : fill;
        mem_v[wr_ptr] <= bus.valid_in;
      end
      if (bus.en) wr_ptr <= wr_ptr == PW'(MAX_DELAY - 1) ? '0 : wr_ptr + PW'(1);
    end
  end
endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line: directed self-checking bench for prog_delay_line
module tb_prog_delay_line;
  logic clk = 0;
  logic rst;
  int total = 0;
  int bad = 0;
  int n;
  prog_delay_line_if #(.SIZE(8), .MAX_DELAY(16)) bus ();
  prog_delay_line #(.SIZE(8), .MAX_DELAY(16), .DEFAULT_DELAY(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic b);
    chk({tag, "_valid"}, 32'(bus.valid_out), 32'(v));
    chk({tag, "_data"}, 32'(bus.data_out), 32'(d));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(b));
  endtask
  initial begin
    rst = 1;
    bus.en = 0;
    bus.delay_load = 0;
    bus.delay_sel = '0;
    bus.valid_in = 0;
    bus.data_in = '0;
    tick();
    rst = 0;
    chk_out("reset", 0, 8'h00, 1);
    bus.en = 1;
    bus.valid_in = 1;
    for (int i = 1; i <= 6; i++) begin
      bus.data_in = 8'(i);
      tick();
      chk_out("stream_d1", 1, 8'(i), 0);
    end
    for (int t = 0; t < 56; t++) begin
      bus.delay_load = t == 0;
      bus.delay_sel = 5'd16;
      bus.valid_in = t < 40;
      bus.data_in = 8'(t + 1);
      tick();
      chk_out("max_wrap", t >= 15 && t < 55, (t >= 15 && t < 55) ? 8'(t - 14) : 8'h00, t < 15);
    end
    n = 0;
    bus.valid_in = 1;
    for (int s = 0; s < 12; s++) begin
      bus.delay_load = s == 0;
      bus.delay_sel = 5'd4;
      bus.en = !(s >= 5 && s <= 7);
      bus.data_in = bus.en ? 8'(8'h80 + n + 1) : 8'hEE;
      tick();
      if (bus.en) n++;
      chk_out("stall", n >= 4, n >= 4 ? 8'(8'h80 + n - 3) : 8'h00, n < 4);
    end
    bus.en = 1;
    for (int s = 0; s < 6; s++) begin
      bus.delay_load = s == 0;
      bus.delay_sel = 5'd3;
      bus.data_in = 8'(8'h90 + s + 1);
      tick();
      chk_out("delay3", s >= 2, s >= 2 ? 8'(8'h90 + s - 1) : 8'h00, s < 2);
    end
    for (int t = 0; t < 20; t++) begin
      bus.delay_load = t == 0;
      bus.delay_sel = 5'd20;
      bus.data_in = 8'(8'hC0 + t);
      tick();
      chk_out("clamp", t >= 15, t >= 15 ? 8'(8'hC0 + t - 15) : 8'h00, t < 15);
    end
    bus.delay_load = 1;
    bus.delay_sel = 5'd0;
    tick();
    bus.delay_load = 0;
    bus.valid_in = 1;
    bus.data_in = 8'hA5;
    #1;
    chk_out("bypass_on", 1, 8'hA5, 0);
    bus.valid_in = 0;
    #1;
    chk_out("bypass_off", 0, 8'h00, 0);
    bus.valid_in = 1;
    for (int s = 0; s < 8; s++) begin
      bus.delay_load = s == 0;
      bus.delay_sel = 5'd5;
      bus.data_in = 8'(8'h50 + s);
      tick();
    end
    chk_out("full_d5", 1, 8'h53, 0);
    rst = 1;
    bus.delay_load = 1;
    bus.delay_sel = 5'd9;
    bus.data_in = 8'hFF;
    tick();
    rst = 0;
    bus.delay_load = 0;
    chk_out("mid_reset", 0, 8'h00, 1);
    bus.data_in = 8'h33;
    tick();
    chk_out("post_reset_d1", 1, 8'h33, 0);
    bus.valid_in = 0;
    bus.data_in = 8'h00;
    for (int s = 0; s < 6; s++) begin
      tick();
      chk_out("no_stale", 0, 8'h00, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
